cpld_andn_qual: RTL and testbench

CPLD_ANDN_QUAL -- requirements
Module: cpld_andn_qual

---
 rtl/cpld_andn_qual.sv | 116 +++++++++++
 tb/tb_cpld_andn_qual.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpld_andn_qual.sv
// Wide AND gate with an optional debounce qualifier: Z0 is asserted only after
// HOLD consecutive enabled all-high samples. Z1 flags Z0 rising, Z2 is the raw AND.
module cpld_andn_qual #(
    parameter int WIDTH = 2,
    parameter int HOLD  = 4,
    parameter int MODE  = 1
) (
    input  logic             CLK,
    input  logic             CD,
    input  logic             CE,
    input  logic [WIDTH-1:0] A,
    output logic             Z0,
    output logic             Z1,
    output logic             Z2
);

    localparam int CNT_W = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("cpld_andn_qual: WIDTH must be 2..16");
    end
    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("cpld_andn_qual: HOLD must be 1..255");
    end
    if (MODE < 0 || MODE > 1) begin : g_bad_mode
        $error("cpld_andn_qual: MODE must be 0 or 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        ON   = 2'd2
    } state_t;

    state_t           state_p0;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             and_all;
    logic             z0_nxt;

    assign and_all = &A;
    assign cnt_inc = cnt_p0 + ONE_C;

    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0;
        z0_nxt    = Z0;
        if (CE) begin
            if (MODE == 0) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                z0_nxt    = and_all;
            end else begin
                case (state_p0)
                    IDLE: begin
                        if (and_all) begin
                            cnt_nxt   = ONE_C;
                            state_nxt = (HOLD == 1) ? ON : QUAL;
                        end else begin
                            cnt_nxt   = '0;
                        end
                    end
                    QUAL: begin
                        // Any low sample throws away the partial run.
                        if (and_all) begin
                            cnt_nxt = cnt_inc;
                            if (cnt_inc == HOLD_C) begin
                                state_nxt = ON;
                            end
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                    ON: begin
                        if (and_all) begin
                            cnt_nxt   = HOLD_C;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
                z0_nxt = (state_nxt == ON);
            end
        end
    end

    // Z1 updates on every edge so a pulse always ends after one clock, even with CE low.
    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
            Z0       <= 1'b0;
            Z1       <= 1'b0;
            Z2       <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
            Z0       <= z0_nxt;
            Z1       <= z0_nxt & ~Z0;
            if (CE) begin
                Z2 <= and_all;
            end
        end
    end

endmodule

// File: tb/tb_cpld_andn_qual.sv
// Scoreboard bench for cpld_andn_qual: four parameter variants driven in lockstep,
// each compared against a run-length reference model every clock.
module tb_cpld_andn_qual;

    localparam int N = 4;
    localparam int HOLDS [N] = '{4, 4, 1, 7};
    localparam int MODES [N] = '{1, 0, 1, 1};
    localparam int WS    [N] = '{2, 16, 2, 5};

    logic              clk = 1'b0;
    logic              cd  = 1'b1;
    logic [N-1:0]      ce  = '0;
    logic [15:0]       a_v [N];
    logic [N-1:0]      z0, z1, z2;

    int checks = 0;
    int errors = 0;

    int   run [N];
    bit   mz0 [N];
    bit   mz1 [N];
    bit   mz2 [N];
    logic [3*N-1:0] exp_q [$];

    always #5 clk = ~clk;

    cpld_andn_qual #(.WIDTH(2),  .HOLD(4), .MODE(1)) u_d0 (
        .CLK(clk), .CD(cd), .CE(ce[0]), .A(a_v[0][1:0]), .Z0(z0[0]), .Z1(z1[0]), .Z2(z2[0]));
    cpld_andn_qual #(.WIDTH(16), .HOLD(4), .MODE(0)) u_d1 (
        .CLK(clk), .CD(cd), .CE(ce[1]), .A(a_v[1]),      .Z0(z0[1]), .Z1(z1[1]), .Z2(z2[1]));
    cpld_andn_qual #(.WIDTH(2),  .HOLD(1), .MODE(1)) u_d2 (
        .CLK(clk), .CD(cd), .CE(ce[2]), .A(a_v[2][1:0]), .Z0(z0[2]), .Z1(z1[2]), .Z2(z2[2]));
    cpld_andn_qual #(.WIDTH(5),  .HOLD(7), .MODE(1)) u_d3 (
        .CLK(clk), .CD(cd), .CE(ce[3]), .A(a_v[3][4:0]), .Z0(z0[3]), .Z1(z1[3]), .Z2(z2[3]));

    function automatic logic [15:0] mask_of(input int d);
        return 16'((32'd1 << WS[d]) - 1);
    endfunction

    // Reference: Z0 is high once the run of enabled all-high samples reaches HOLD.
    task automatic model_step(input int d, input bit cev, input logic [15:0] av);
        bit all_hi;
        bit new_z0;
        new_z0 = mz0[d];
        if (cev) begin
            all_hi = ((av & mask_of(d)) == mask_of(d));
            mz2[d] = all_hi;
            if (MODES[d] == 0) begin
                new_z0 = all_hi;
            end else begin
                run[d] = all_hi ? ((run[d] < HOLDS[d]) ? run[d] + 1 : run[d]) : 0;
                new_z0 = (run[d] >= HOLDS[d]);
            end
        end
        mz1[d] = new_z0 && !mz0[d];
        mz0[d] = new_z0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            run[d] = 0; mz0[d] = 0; mz1[d] = 0; mz2[d] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < N; d++) begin
            checks++;
            if ({z0[d], z1[d], z2[d]} !== 3'b000) begin
                errors++;
                $display("FAIL %s dut%0d z0z1z2 got %b expected 000", tag, d, {z0[d], z1[d], z2[d]});
            end
        end
    endtask

    // One sample period: drive at the falling edge, optionally pulse CD, push the expectation.
    task automatic step(input logic [N-1:0] cev, input logic [15:0] av0, input logic [15:0] av1,
                        input logic [15:0] av2, input logic [15:0] av3, input bit rst_pulse);
        logic [3*N-1:0] e;
        @(negedge clk);
        ce = cev;
        a_v[0] = av0; a_v[1] = av1; a_v[2] = av2; a_v[3] = av3;
        if (rst_pulse) begin
            #1 cd = 1'b1;
            #1 check_zero("async_reset");
            #1 cd = 1'b0;
            model_reset();
        end
        for (int d = 0; d < N; d++) begin
            model_step(d, cev[d], a_v[d]);
            e[3*d +: 3] = {mz0[d], mz1[d], mz2[d]};
        end
        exp_q.push_back(e);
    endtask

    task automatic step_all(input bit cev, input logic [15:0] av);
        step({N{cev}}, av, av, av, av, 1'b0);
    endtask

    // Monitor: outputs are presented every clock, so every edge with a pending entry is checked.
    always begin
        logic [3*N-1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int d = 0; d < N; d++) begin
                checks++;
                if ({z0[d], z1[d], z2[d]} !== e[3*d +: 3]) begin
                    errors++;
                    $display("FAIL scoreboard dut%0d t=%0t z0z1z2 got %b expected %b",
                             d, $time, {z0[d], z1[d], z2[d]}, e[3*d +: 3]);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < N; d++) a_v[d] = '0;
        model_reset();
        #2 check_zero("reset_state");
        #1 cd = 1'b0;

        // Continuous all-high from the first sample.
        for (int i = 0; i < 7; i++) step_all(1'b1, 16'hFFFF);
        step_all(1'b1, 16'h0000);

        // Three high samples, one broken sample, then a fresh run.
        for (int i = 0; i < 3; i++) step_all(1'b1, 16'hFFFF);
        step_all(1'b1, 16'hFFFE);
        for (int i = 0; i < 9; i++) step_all(1'b1, 16'hFFFF);
        step_all(1'b1, 16'h0000);

        // Clock enable low on alternate edges.
        for (int i = 0; i < 18; i++) step_all(i[0] == 1'b0, 16'hFFFF);
        step_all(1'b1, 16'h0000);

        // Reach ON, pulse CD between edges, requalify.
        for (int i = 0; i < 8; i++) step_all(1'b1, 16'hFFFF);
        step({N{1'b1}}, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < 9; i++) step_all(1'b1, 16'hFFFF);

        // Toggling FFFF / FFFE every sample.
        for (int i = 0; i < 10; i++) step_all(1'b1, i[0] ? 16'hFFFE : 16'hFFFF);

        // Randomized, biased toward all-high so qualification completes often.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r [N];
            logic [N-1:0] cr;
            for (int d = 0; d < N; d++) begin
                r[d]  = ($urandom_range(0, 99) < 80) ? 16'hFFFF : 16'($urandom);
                cr[d] = ($urandom_range(0, 99) < 80);
            end
            step(cr, r[0], r[1], r[2], r[3], ($urandom_range(0, 99) < 2));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
